// File: rtl/ka_split_mul_6bit.sv
// Upstream stage of the 6-bit Karatsuba GF(2) multiplier: one bit-serial
// shift-and-XOR unit produces the low, high and corrected middle partial products in turn.
module ka_split_mul_6bit #(
    parameter int unsigned N = 6
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [N-1:0] a,
    input  logic [N-1:0] b,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [N-2:0] B2_in1,
    output logic [N-2:0] B2_in2,
    output logic [N-2:0] B2_in3
);

    localparam int unsigned H  = N / 2;
    localparam int unsigned W  = N - 1;
    localparam int unsigned CW = (H > 1) ? $clog2(H) : 1;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        MUL_L = 3'd1,
        MUL_H = 3'd2,
        MUL_M = 3'd3,
        DONE  = 3'd4
    } state_e;

    state_e          state_q, state_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [W-1:0]    acc_q, acc_d;
    logic [N-1:0]    a_q, a_d;
    logic [N-1:0]    b_q, b_d;
    logic            out_valid_q, out_valid_d;
    logic            in_ready_q, in_ready_d;
    logic [W-1:0]    b2_in1_q, b2_in1_d;
    logic [W-1:0]    b2_in2_q, b2_in2_d;
    logic [W-1:0]    b2_in3_q, b2_in3_d;

    logic [H-1:0]    aop, bop;
    logic [W-1:0]    term;
    logic [W-1:0]    fin;
    logic            last;

    // State register and datapath flops
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            acc_q       <= '0;
            a_q         <= '0;
            b_q         <= '0;
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
            b2_in1_q    <= '0;
            b2_in2_q    <= '0;
            b2_in3_q    <= '0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            acc_q       <= acc_d;
            a_q         <= a_d;
            b_q         <= b_d;
            out_valid_q <= out_valid_d;
            in_ready_q  <= in_ready_d;
            b2_in1_q    <= b2_in1_d;
            b2_in2_q    <= b2_in2_d;
            b2_in3_q    <= b2_in3_d;
        end
    end

    // Next-state, phase operand select and shift-and-XOR step
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        acc_d       = acc_q;
        a_d         = a_q;
        b_d         = b_q;
        out_valid_d = out_valid_q;
        b2_in1_d    = b2_in1_q;
        b2_in2_d    = b2_in2_q;
        b2_in3_d    = b2_in3_q;
        aop         = '0;
        bop         = '0;

        case (state_q)
            MUL_L: begin
                aop = a_q[H-1:0];
                bop = b_q[H-1:0];
            end
            MUL_H: begin
                aop = a_q[N-1:H];
                bop = b_q[N-1:H];
            end
            MUL_M: begin
                aop = a_q[H-1:0] ^ a_q[N-1:H];
                bop = b_q[H-1:0] ^ b_q[N-1:H];
            end
            default: begin
                aop = '0;
                bop = '0;
            end
        endcase

        term = bop[cnt_q] ? (W'(aop) << cnt_q) : '0;
        fin  = acc_q ^ term;
        last = (cnt_q == CW'(H - 1));

        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    a_d     = a;
                    b_d     = b;
                    acc_d   = '0;
                    cnt_d   = '0;
                    state_d = MUL_L;
                end
            end
            MUL_L, MUL_H, MUL_M: begin
                if (last) begin
                    acc_d = '0;
                    cnt_d = '0;
                    if (state_q == MUL_L) begin
                        b2_in1_d = fin;
                        state_d  = MUL_H;
                    end else if (state_q == MUL_H) begin
                        b2_in3_d = fin;
                        state_d  = MUL_M;
                    end else begin
                        // Karatsuba correction folds L and H out of the middle product
                        b2_in2_d    = fin ^ b2_in1_q ^ b2_in3_q;
                        out_valid_d = 1'b1;
                        state_d     = DONE;
                    end
                end else begin
                    acc_d = fin;
                    cnt_d = cnt_q + CW'(1);
                end
            end
            DONE: begin
                if (out_ready) begin
                    out_valid_d = 1'b0;
                    state_d     = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        in_ready_d = (state_d == IDLE);
    end

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign B2_in1    = b2_in1_q;
    assign B2_in2    = b2_in2_q;
    assign B2_in3    = b2_in3_q;

endmodule

// File: tb/tb_ka_split_mul_6bit.sv
// Directed and random checks for the Karatsuba split stage.
module tb_ka_split_mul_6bit;

    logic       clk;
    logic       rst_n;
    logic       in_valid;
    logic       in_ready;
    logic [5:0] a;
    logic [5:0] b;
    logic       out_valid;
    logic       out_ready;
    logic [4:0] B2_in1;
    logic [4:0] B2_in2;
    logic [4:0] B2_in3;

    int n_checks;
    int n_errors;

    ka_split_mul_6bit dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .B2_in1    (B2_in1),
        .B2_in2    (B2_in2),
        .B2_in3    (B2_in3)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic logic [10:0] clmul6(input logic [5:0] x, input logic [5:0] y);
        logic [10:0] r;
        r = '0;
        for (int i = 0; i < 6; i++)
            if (y[i]) r = r ^ (11'(x) << i);
        return r;
    endfunction

    // One full transaction; noise scribbles on the inputs while busy, bp holds off out_ready.
    task automatic do_op(input logic [5:0] ta, input logic [5:0] tb_v,
                         input bit directed, input logic [4:0] e1, input logic [4:0] e2,
                         input logic [4:0] e3, input bit noise, input int bp, input string tag);
        int          lat;
        int          rdy_hi;
        int          unstable;
        logic [4:0]  s1, s2, s3;
        logic [10:0] comb;
        @(negedge clk);
        check({tag, "_in_ready_idle"}, 32'(in_ready), 32'd1);
        a        = ta;
        b        = tb_v;
        in_valid = 1'b1;
        @(negedge clk);
        if (!noise) in_valid = 1'b0;
        lat    = 0;
        rdy_hi = 0;
        while (!out_valid && lat < 30) begin
            if (in_ready) rdy_hi++;
            if (noise) begin
                a = 6'($urandom);
                b = 6'($urandom);
            end
            @(negedge clk);
            lat++;
        end
        in_valid = 1'b0;
        check({tag, "_latency"}, 32'(lat), 32'd9);
        if (directed) begin
            check({tag, "_B2_in1"}, 32'(B2_in1), 32'(e1));
            check({tag, "_B2_in2"}, 32'(B2_in2), 32'(e2));
            check({tag, "_B2_in3"}, 32'(B2_in3), 32'(e3));
        end else begin
            comb = 11'(B2_in1) ^ (11'(B2_in2) << 3) ^ (11'(B2_in3) << 6);
            check({tag, "_product"}, 32'(comb), 32'(clmul6(ta, tb_v)));
        end
        s1 = B2_in1;
        s2 = B2_in2;
        s3 = B2_in3;
        unstable = 0;
        for (int i = 0; i < bp; i++) begin
            @(negedge clk);
            if (in_ready) rdy_hi++;
            if (!out_valid || B2_in1 !== s1 || B2_in2 !== s2 || B2_in3 !== s3) unstable++;
        end
        if (bp > 0) check({tag, "_bp_stable"}, 32'(unstable), 32'd0);
        if (noise || bp > 0) check({tag, "_busy_in_ready_low"}, 32'(rdy_hi), 32'd0);
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        check({tag, "_out_valid_cleared"}, 32'(out_valid), 32'd0);
        check({tag, "_in_ready_after"}, 32'(in_ready), 32'd1);
    endtask

    initial begin
        int seen;
        n_checks  = 0;
        n_errors  = 0;
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        a         = '0;
        b         = '0;
        repeat (2) @(negedge clk);
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_in_ready", 32'(in_ready), 32'd1);
        check("rst_outputs", {17'd0, B2_in1, B2_in2, B2_in3}, 32'd0);
        rst_n = 1'b1;

        // Stray out_ready while idle must not disturb anything
        out_ready = 1'b1;
        repeat (2) @(negedge clk);
        out_ready = 1'b0;
        check("idle_out_ready_ignored", 32'(out_valid), 32'd0);

        do_op(6'h3F, 6'h3F, 1'b1, 5'h15, 5'h00, 5'h15, 1'b0, 0, "t1");
        do_op(6'h01, 6'h01, 1'b1, 5'h01, 5'h00, 5'h00, 1'b0, 0, "t2");
        do_op(6'h08, 6'h01, 1'b1, 5'h00, 5'h01, 5'h00, 1'b0, 0, "t3");
        do_op(6'h03, 6'h06, 1'b1, 5'h0A, 5'h00, 5'h00, 1'b1, 0, "t4");
        do_op(6'h2D, 6'h13, 1'b0, 5'h00, 5'h00, 5'h00, 1'b0, 5, "t5");

        // Reset landing in MUL_H: B2_in1 already written, must clear
        @(negedge clk);
        a        = 6'h3F;
        b        = 6'h3F;
        in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        repeat (4) @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("rst_mid_out_valid", 32'(out_valid), 32'd0);
        check("rst_mid_in_ready", 32'(in_ready), 32'd1);
        check("rst_mid_outputs", {17'd0, B2_in1, B2_in2, B2_in3}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        seen = 0;
        repeat (12) begin
            @(negedge clk);
            if (out_valid) seen++;
        end
        check("rst_mid_no_pulse", 32'(seen), 32'd0);
        do_op(6'h24, 6'h39, 1'b0, 5'h00, 5'h00, 5'h00, 1'b0, 0, "t6");

        for (int i = 0; i < 1000; i++)
            do_op(6'($urandom), 6'($urandom), 1'b0, 5'h00, 5'h00, 5'h00, 1'b0, 0, "rnd");

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
